if_fetch: RTL and testbench

Instruction-fetch front end that consumes the architectural PC and drives the PC update enable. It issues in-order requests to instruction memory over a valid/ready channel, buffers returned words in a small FIFO, and presents (pc, inst) pairs to decode over a valid/ready handshake. Redirects flush all in-flight and buffered fetches.

---
 rtl/if_pkg.sv | 19 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/if_fetch.sv | 147 ++++++++++++++
 tb/tb_if_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Fetch entries carry the PC, the instruction word and an address-error flag.
package if_pkg;

   localparam logic [31:0] BEGIN_ADDR = 32'h1C00_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adef;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_ADEF
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a synchronous clear.
// A push into a full FIFO is legal when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage is left unreset so it can map onto distributed/block RAM.
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst_n && !clr) assert (!(push && full && !pop));
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: credit-limited in-order requests to imem,
// response pairing through a pending-PC queue, and an output FIFO to decode.
module if_fetch #(
   parameter int          DEPTH      = 2,
   parameter logic [31:0] BEGIN_ADDR = if_pkg::BEGIN_ADDR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   output logic        pc_en,
   input  logic        flush,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_pc,
   output logic [31:0] inst,
   output logic        inst_adef
);

   import if_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = $bits(fetch_entry_t);

   state_t         state_reg, state_next;
   logic [CW-1:0]  outstanding_reg, outstanding_next;
   logic [CW-1:0]  drop_reg, drop_next;

   logic           running, aligned, flush_act;
   logic           credit, fire, adef_go, rsp_take, rsp_drop, pop_go;
   logic [CW:0]    inflight;

   logic [31:0]    pend_dout;
   logic           pend_full, pend_empty;
   logic [CW-1:0]  pend_count;

   fetch_entry_t   out_din, out_dout;
   logic           out_push, out_full, out_empty;
   logic [CW-1:0]  out_count;

   assign running   = (state_reg == S_RUN);
   assign aligned   = (pc[1:0] == 2'b00);
   assign flush_act = flush & (state_reg != S_IDLE);
   assign pop_go    = ~out_empty & inst_ready & ~flush_act;

   // An entry leaving the FIFO this cycle frees its credit immediately,
   // which keeps a single-cycle-latency memory streaming at one per cycle.
   assign inflight = {1'b0, outstanding_reg} + {1'b0, out_count} + {1'b0, drop_reg}
                   - {{CW{1'b0}}, pop_go};
   assign credit   = (inflight < (CW+1)'(DEPTH));

   assign imem_req_valid = running & credit & aligned & ~flush;
   assign imem_req_addr  = imem_req_valid ? pc : '0;
   assign fire           = imem_req_valid & imem_req_ready;
   assign pc_en          = fire | flush_act;

   // The error entry waits for older responses so it lands behind them.
   assign adef_go  = running & ~aligned & credit & ~flush & (outstanding_reg == '0);
   assign rsp_drop = imem_rsp_valid & (drop_reg != '0);
   assign rsp_take = imem_rsp_valid & (drop_reg == '0) & ~flush_act;

   always_comb begin
      out_din  = '{pc: pc, inst: 32'h0, adef: 1'b1};
      out_push = adef_go;
      if (rsp_take) begin
         out_din  = '{pc: pend_dout, inst: imem_rsp_data, adef: 1'b0};
         out_push = 1'b1;
      end
   end

   sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pend (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush_act),
      .push  (fire),
      .din   (pc),
      .pop   (rsp_take),
      .dout  (pend_dout),
      .full  (pend_full),
      .empty (pend_empty),
      .count (pend_count)
   );

   sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_out (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush_act),
      .push  (out_push),
      .din   (out_din),
      .pop   (pop_go),
      .dout  (out_dout),
      .full  (out_full),
      .empty (out_empty),
      .count (out_count)
   );

   always_comb begin
      state_next       = state_reg;
      outstanding_next = outstanding_reg + CW'(fire) - CW'(rsp_take);
      drop_next        = drop_reg - CW'(rsp_drop);
      case (state_reg)
         S_IDLE:  state_next = S_RUN;
         S_RUN:   if (flush) state_next = S_RUN;
                  else if (adef_go) state_next = S_ADEF;
         S_ADEF:  if (flush) state_next = S_RUN;
         default: state_next = S_IDLE;
      endcase
      // Everything still in flight becomes garbage; a response arriving
      // on the flush edge is one of those and is discarded here.
      if (flush_act) begin
         outstanding_next = '0;
         drop_next        = drop_reg + outstanding_reg - CW'(imem_rsp_valid);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= S_IDLE;
         outstanding_reg <= '0;
         drop_reg        <= '0;
      end else begin
         state_reg       <= state_next;
         outstanding_reg <= outstanding_next;
         drop_reg        <= drop_next;
      end
   end

   assign inst_valid = ~out_empty;
   assign inst_pc    = inst_valid ? out_dout.pc   : '0;
   assign inst       = inst_valid ? out_dout.inst : '0;
   assign inst_adef  = inst_valid & out_dout.adef;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (BEGIN_ADDR[1:0] == 2'b00 && DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0);
         assert (pend_count == outstanding_reg);
         assert (!(rsp_take && pend_empty));
         assert (!(fire && pend_full));
         assert (!(adef_go && out_full));
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed and randomized bench for if_fetch: a behavioural memory and PC
// register, with the delivered (pc, inst) stream checked against address order.
module tb_if_fetch;

   localparam int          DEPTH = 2;
   localparam logic [31:0] BASE  = 32'h1C00_0000;

   logic        clk, rst_n, pc_en, flush;
   logic [31:0] pc;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_req_addr, imem_rsp_data;
   logic        inst_valid, inst_ready, inst_adef;
   logic [31:0] inst_pc, inst;

   if_fetch #(.DEPTH(DEPTH), .BEGIN_ADDR(BASE)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc             (pc),
      .pc_en          (pc_en),
      .flush          (flush),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_pc        (inst_pc),
      .inst           (inst),
      .inst_adef      (inst_adef)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   mreq_t       mq[$];
   logic [31:0] got_pc[$];

   int n_vec = 0, n_bad = 0;
   int n_fire = 0, n_deliv = 0, n_pc_en = 0, cyc = 0;
   int ready_pct = 100, iready_pct = 100, lat_min = 1, lat_max = 1;
   logic [31:0] exp_pc = BASE;
   bit          stalled = 0, post_flush = 0;
   logic        s_req_valid, s_pc_en, s_fire, s_inst_valid;
   logic [31:0] s_req_addr, s_inst_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0280_0000 ^ ((a - BASE) * 32'h0001_0003);
   endfunction

   function automatic logic [31:0] got_at(input int i);
      if (i < got_pc.size()) return got_pc[i];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_req_valid"}, imem_req_valid, 0);
      check({tag, "_req_addr"}, imem_req_addr, 0);
      check({tag, "_pc_en"}, pc_en, 0);
      check({tag, "_inst_valid"}, inst_valid, 0);
      check({tag, "_inst_pc"}, inst_pc, 0);
      check({tag, "_inst"}, inst, 0);
      check({tag, "_inst_adef"}, inst_adef, 0);
   endtask

   // One clock cycle: drive at posedge+1, check at negedge, update models after posedge.
   task automatic cyc_step(input bit fl, input logic [31:0] tgt);
      mreq_t       m;
      int          lat;
      logic        adef_exp;
      imem_req_ready = (int'($urandom_range(99)) < ready_pct);
      inst_ready     = (int'($urandom_range(99)) < iready_pct);
      flush          = fl;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         m = mq.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(m.addr);
      end
      @(negedge clk);
      s_req_valid  = imem_req_valid;
      s_req_addr   = imem_req_addr;
      s_pc_en      = pc_en;
      s_fire       = imem_req_valid & imem_req_ready;
      s_inst_valid = inst_valid;
      s_inst_pc    = inst_pc;
      if (post_flush) check("inst_valid_after_flush", inst_valid, 0);
      if (stalled) check("adef_no_req", imem_req_valid, 0);
      if (imem_req_valid) begin
         check("req_addr", imem_req_addr, pc);
         check("req_aligned", pc[1:0], 0);
         check("req_on_flush", fl, 0);
      end
      check("pc_en", pc_en, s_fire | fl);
      check("mem_inflight_le_depth",
            (mq.size() + int'(imem_rsp_valid) + int'(s_fire)) <= DEPTH, 1);
      if (inst_valid && inst_ready && !fl) begin
         adef_exp = (exp_pc[1:0] != 2'b00);
         n_deliv++;
         got_pc.push_back(inst_pc);
         check("deliver_after_adef", stalled, 0);
         check("inst_pc", inst_pc, exp_pc);
         check("inst_adef", inst_adef, adef_exp);
         check("inst_word", inst, adef_exp ? 32'h0 : mem_word(exp_pc));
         if (adef_exp) stalled = 1;
         exp_pc = exp_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      if (s_fire) begin
         lat = int'($urandom_range(lat_max, lat_min));
         mq.push_back('{addr: pc, due: cyc + lat});
         n_fire++;
      end
      if (s_pc_en) n_pc_en++;
      if (fl) begin
         pc      = tgt;
         exp_pc  = tgt;
         stalled = 0;
      end else if (s_pc_en) begin
         pc = pc + 32'd4;
      end
      post_flush = fl;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc_step(1'b0, 32'h0);
   endtask

   initial begin
      int d0, p0, f0;
      logic [31:0] tgt;
      rst_n = 1'b0; pc = BASE; flush = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;

      // Reset state and first fetch
      #12;
      check_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc_step(1'b0, 32'h0);
      check("idle_no_req", s_req_valid, 0);
      cyc_step(1'b0, 32'h0);
      check("first_req_valid", s_req_valid, 1);
      check("first_req_addr", s_req_addr, BASE);
      check("first_pc_en", s_pc_en, 1);
      cyc_step(1'b0, 32'h0);
      cyc_step(1'b0, 32'h0);
      check("first_inst_valid", s_inst_valid, 1);
      check("first_inst_pc", s_inst_pc, BASE);

      // Streaming, one-cycle memory latency
      run(4);
      d0 = n_deliv; p0 = n_pc_en;
      run(16);
      check("stream_pc_en_cycles", n_pc_en - p0, 16);
      check("stream_deliveries", n_deliv - d0, 16);

      // Decode backpressure: only DEPTH requests may issue
      iready_pct = 0;
      f0 = n_fire;
      cyc_step(1'b1, BASE);
      run(10);
      check("bp_fire_count", n_fire - f0, DEPTH);
      check("bp_req_valid", s_req_valid, 0);
      check("bp_pc_en", s_pc_en, 0);
      iready_pct = 100;
      got_pc.delete();
      run(4);
      check("bp_first", got_at(0), BASE);
      check("bp_second", got_at(1), BASE + 32'd4);

      // Flush with two requests in flight: both responses are dropped
      ready_pct = 0;
      cyc_step(1'b1, 32'h1C00_0200);
      run(6);
      lat_min = 3; lat_max = 3; ready_pct = 100; iready_pct = 0;
      cyc_step(1'b0, 32'h0);
      check("drop_fire_a", s_fire, 1);
      cyc_step(1'b0, 32'h0);
      check("drop_fire_b", s_fire, 1);
      iready_pct = 100;
      cyc_step(1'b1, 32'h1C00_0100);
      check("drop_no_req_on_flush", s_req_valid, 0);
      got_pc.delete();
      for (int i = 1; i <= 4; i++) begin
         cyc_step(1'b0, 32'h0);
         check("drop_inst_valid_low", s_inst_valid, 0);
         if (i == 2) begin
            check("drop_refetch_fire", s_fire, 1);
            check("drop_refetch_addr", s_req_addr, 32'h1C00_0100);
         end
      end
      lat_min = 1; lat_max = 1;
      run(8);
      check("drop_first_after", got_at(0), 32'h1C00_0100);

      // Misaligned PC: address-error entry, stall until flush
      lat_max = 2;
      got_pc.delete();
      f0 = n_fire;
      cyc_step(1'b1, 32'h1C00_0002);
      run(12);
      check("adef_no_fire", n_fire - f0, 0);
      check("adef_one_entry", got_pc.size(), 1);
      check("adef_entry_pc", got_at(0), 32'h1C00_0002);
      got_pc.delete();
      cyc_step(1'b1, 32'h1C00_0300);
      run(8);
      check("adef_resume_pc", got_at(0), 32'h1C00_0300);

      // Randomized traffic with random redirects
      ready_pct = 70; iready_pct = 60; lat_min = 1; lat_max = 4;
      d0 = n_deliv;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(99) < 3) begin
            tgt = BASE + ($urandom_range(63) << 2) + (($urandom_range(7) == 0) ? 32'd2 : 32'd0);
            cyc_step(1'b1, tgt);
         end else begin
            cyc_step(1'b0, 32'h0);
         end
      end
      check("random_progress", (n_deliv - d0) >= 20, 1);

      // Asynchronous reset with the output FIFO full
      ready_pct = 100; iready_pct = 0; lat_min = 1; lat_max = 1;
      cyc_step(1'b1, 32'h1C00_0040);
      run(6);
      check("pre_reset_full", s_inst_valid, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      @(posedge clk);
      @(posedge clk); #1;
      mq.delete();
      pc = BASE; exp_pc = BASE; stalled = 0; post_flush = 0;
      iready_pct = 100;
      rst_n = 1'b1;
      cyc_step(1'b0, 32'h0);
      check("rst_idle_no_req", s_req_valid, 0);
      cyc_step(1'b0, 32'h0);
      check("rst_restart_req", s_req_valid, 1);
      check("rst_restart_addr", s_req_addr, BASE);
      got_pc.delete();
      run(6);
      check("rst_restart_first", got_at(0), BASE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
